// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: segment word layout,
// blank pattern and the scan FSM state type.
package seg7_pkg;

  localparam int SEG_W = 8;
  typedef logic [SEG_W-1:0] seg_word_t;

  // Bit positions inside the segment word; a is the MSB of the a..g field.
  localparam int SEG_DP = 7;
  localparam int SEG_A  = 6;
  localparam int SEG_B  = 5;
  localparam int SEG_C  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 2;
  localparam int SEG_F  = 1;
  localparam int SEG_G  = 0;

  localparam seg_word_t SEG_BLANK = 8'h00;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to segment pattern (a..g active-high in [6:0]).
// Bit 7 is always 0; the caller merges in the decimal point.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_word_t  pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = 8'h7E;
      4'h1: pattern = 8'h30;
      4'h2: pattern = 8'h6D;
      4'h3: pattern = 8'h79;
      4'h4: pattern = 8'h33;
      4'h5: pattern = 8'h5B;
      4'h6: pattern = 8'h5F;
      4'h7: pattern = 8'h70;
      4'h8: pattern = 8'h7F;
      4'h9: pattern = 8'h7B;
      4'hA: pattern = 8'h77;
      4'hB: pattern = 8'h1F;
      4'hC: pattern = 8'h4E;
      4'hD: pattern = 8'h3D;
      4'hE: pattern = 8'h4F;
      4'hF: pattern = 8'h47;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with blanking gaps
// and tear-free frame updates committed only at the start of digit 0.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic [NUM_DIGITS-1:0]   load_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int DIG_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [DIG_W-1:0] IDX_LAST   = DIG_W'(NUM_DIGITS - 1);
  localparam scan_state_t      FIRST_ST   = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  scan_state_t             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIG_W-1:0]        idx_q, idx_d;
  logic                    boot_q, boot_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_en_q, shadow_en_d;
  logic [4*NUM_DIGITS-1:0] active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [NUM_DIGITS-1:0]   active_en_q, active_en_d;
  seg_word_t               seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  logic      transfer;
  logic      frame_entry;
  logic      show_lit;
  logic [3:0] cur_nibble;
  seg_word_t dec_pattern;

  assign load_ready = ~pending_q & ~rst;
  assign transfer   = load_valid & load_ready;

  // The first edge after reset is treated as entering digit 0 so the frame
  // cadence starts cleanly from reset release.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    boot_d      = 1'b0;
    frame_entry = 1'b0;
    if (boot_q) begin
      state_d     = FIRST_ST;
      cnt_d       = '0;
      idx_d       = '0;
      frame_entry = 1'b1;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end
        end
        ST_SHOW: begin
          if (cnt_q == DIGIT_LAST) begin
            state_d     = FIRST_ST;
            cnt_d       = '0;
            idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            frame_entry = (idx_q == IDX_LAST);
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  always_comb begin
    pending_d     = pending_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_en_d   = shadow_en_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    active_en_d   = active_en_q;
    frame_start_d = frame_entry;
    if (frame_entry && pending_q) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      active_en_d   = shadow_en_q;
      pending_d     = 1'b0;
    end
    // Never coincides with a commit of pending data: ready is low while pending.
    if (transfer) begin
      shadow_data_d = load_data;
      shadow_dp_d   = load_dp;
      shadow_en_d   = load_en;
      pending_d     = 1'b1;
    end
  end

  assign show_lit   = (state_q == ST_SHOW) & active_en_q[idx_q];
  assign cur_nibble = active_data_q[{idx_q, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .nibble  (cur_nibble),
    .pattern (dec_pattern)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_d[gi] = ~(show_lit & (idx_q == DIG_W'(gi)));
  end

  always_comb begin
    seg_d = SEG_BLANK;
    if (show_lit) begin
      seg_d         = dec_pattern;
      seg_d[SEG_DP] = active_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      boot_q        <= 1'b1;
      pending_q     <= 1'b0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_en_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      active_en_q   <= '0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      boot_q        <= boot_d;
      pending_q     <= pending_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_en_q   <= shadow_en_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      active_en_q   <= active_en_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues expected frames, a
// monitor checks every cycle of each frame against them on frame_start.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [3:0]  load_en;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  logic        b_valid;
  logic        b_ready;
  logic [15:0] b_data;
  logic [3:0]  b_dp;
  logic [3:0]  b_en;
  logic [7:0]  b_seg;
  logic [3:0]  b_an;
  logic        b_fs;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .load_en(load_en),
    .seg(seg), .an(an), .frame_start(frame_start)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(0)) dut_nb (
    .clk(clk), .rst(rst), .load_valid(b_valid), .load_ready(b_ready),
    .load_data(b_data), .load_dp(b_dp), .load_en(b_en),
    .seg(b_seg), .an(b_an), .frame_start(b_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-digit anode and segment patterns, digit 0 in the low slice.
  typedef struct packed {
    logic [15:0] an_p;
    logic [31:0] seg_p;
  } frame_t;

  localparam frame_t F_BLANK = '{an_p: 16'hFFFF, seg_p: 32'h0000_0000};
  localparam frame_t F_3210  = '{an_p: 16'h7BDE, seg_p: 32'h796D_307E};
  localparam frame_t F_AAAA  = '{an_p: 16'h7BDE, seg_p: 32'h7777_7777};
  localparam frame_t F_EN    = '{an_p: 16'hFBFE, seg_p: 32'h007F_00FF};

  int errors = 0;
  int checks = 0;
  int frames_done = 0;
  bit b_done = 0;
  frame_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic wait_fs();
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = frame_start;
    end
    if (!got) check("timeout_frame_start", 32'd0, 32'd1);
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_data  = d;
    load_dp    = dp;
    load_en    = en;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    $display("offer data=%h dp=%b en=%b", d, dp, en);
  endtask

  // Monitor: each frame_start pops one expected frame and checks the next
  // 24 cycles (2 blank + 4 lit per digit, outputs one cycle behind state).
  initial begin
    frame_t cur;
    int k;
    int j;
    int r;
    bit act;
    logic [12:0] req;
    cur = F_BLANK;
    k = 0;
    act = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0;
      end else begin
        if (act) begin
          k++;
          j = (k - 1) / 6;
          r = (k - 1) % 6;
          if (r < 2) req = {(k == 24), 4'hF, 8'h00};
          else       req = {(k == 24), cur.an_p[4*j +: 4], cur.seg_p[8*j +: 8]};
          check($sformatf("scan f%0d k%0d", frames_done, k),
                {19'd0, frame_start, an, seg}, {19'd0, req});
          if (k == 24) begin
            $display("frame %0d checked an=%h seg=%h", frames_done, cur.an_p, cur.seg_p);
            frames_done++;
            act = 0;
          end
        end
        if (!act && frame_start && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          act = 1;
          k = 0;
        end
      end
    end
  end

  // No-blank variant: load 3210 once, then check two frames of 16 cycles.
  initial begin
    bit got;
    int j;
    b_valid = 1'b0;
    b_data  = 16'h3210;
    b_dp    = 4'h0;
    b_en    = 4'hF;
    for (int f = 0; f < 2; f++) begin
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = b_fs;
      end
      if (!got) check("nb_timeout_frame_start", 32'd0, 32'd1);
      if (f == 0) begin
        @(posedge clk);
        #1 b_valid = 1'b1;
        @(posedge clk);
        #1 b_valid = 1'b0;
        @(negedge clk);
        check("nb_ready_pending", {31'd0, b_ready}, 32'd0);
      end
    end
    for (int f = 1; f <= 2; f++) begin
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        j = (k - 1) / 4;
        check($sformatf("nb_scan f%0d k%0d", f, k), {19'd0, b_fs, b_an, b_seg},
              {19'd0, (k == 16), F_3210.an_p[4*j +: 4], F_3210.seg_p[8*j +: 8]});
      end
      $display("nb frame %0d checked", f);
    end
    b_done = 1;
  end

  initial begin
    bit got;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    load_en    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {24'd0, seg}, 32'h0);
    check("rst_ready", {31'd0, load_ready}, 32'd0);
    check("rst_fs", {31'd0, frame_start}, 32'd0);
    exp_q.push_back(F_BLANK);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    check("first_fs", {31'd0, frame_start}, 32'd1);

    offer(16'h3210, 4'h0, 4'hF);
    @(negedge clk);
    check("pending_ready_low", {31'd0, load_ready}, 32'd0);
    exp_q.push_back(F_3210);
    exp_q.push_back(F_3210);
    wait_fs();
    wait_fs();

    repeat (10) @(posedge clk);
    offer(16'hAAAA, 4'h0, 4'hF);
    exp_q.push_back(F_AAAA);
    exp_q.push_back(F_AAAA);
    load_valid = 1'b1;
    load_data  = 16'h5555;
    load_dp    = 4'hF;
    load_en    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("held_valid_ready", {31'd0, load_ready}, 32'd0);
    end
    @(posedge clk);
    #1 load_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (frame_start) begin
        got = 1;
        check("ready_after_commit", {31'd0, load_ready}, 32'd1);
      end else begin
        check("ready_low_until_commit", {31'd0, load_ready}, 32'd0);
      end
    end
    if (!got) check("timeout_commit", 32'd0, 32'd1);
    wait_fs();

    offer(16'h8888, 4'b0001, 4'b0101);
    exp_q.push_back(F_EN);
    wait_fs();

    offer(16'h3210, 4'h0, 4'hF);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("pre_rst_show_an", {28'd0, an}, 32'hE);
    @(negedge clk);
    check("midrst_an", {28'd0, an}, 32'hF);
    check("midrst_seg", {24'd0, seg}, 32'h0);
    check("midrst_fs", {31'd0, frame_start}, 32'd0);
    check("midrst_ready", {31'd0, load_ready}, 32'd0);
    exp_q.push_back(F_BLANK);
    exp_q.push_back(F_BLANK);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", {31'd0, load_ready}, 32'd1);

    for (int i = 0; i < 120 && frames_done < 7; i++) @(negedge clk);
    check("frames_completed", frames_done, 32'd7);
    check("nb_completed", {31'd0, b_done}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
